pll_rst_seq: RTL



---
 rtl/pll_rst_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset sequencer and lock supervisor
// Drives PLL RST, qualifies LOCK, and releases the system reset once lock has
// been stable. Re-sequences the PLL on lock loss, timeout or software request.
module pll_rst_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int RELEASE_DLY_CYC  = 16,
  parameter int MAX_RETRY        = 7
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_lock_i,
  input  logic       sw_rst_req_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       lock_ok_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o
);

  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (LOCK_STABLE_CYC > RELEASE_DLY_CYC) ? LOCK_STABLE_CYC : RELEASE_DLY_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TMR_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  // Terminal counts: tmr starts at 0 on state entry, so the last cycle is N-1.
  localparam logic [TMR_W-1:0] PRST_LAST = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STAB_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] REL_LAST  = TMR_W'(RELEASE_DLY_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PRST,
    ST_WAIT,
    ST_STAB,
    ST_REL,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             lock_meta;
  logic             lock_s;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       retry_cnt;
  logic [7:0]       loss_cnt;
  logic             tmr_clr;
  logic             retry_inc;
  logic             retry_clr;
  logic             loss_inc;

  // Two-flop synchronizer bringing the asynchronous PLL LOCK into clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_PRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; the software request overrides every other transition.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    loss_inc  = 1'b0;
    if (sw_rst_req_i) begin
      state_nxt = ST_PRST;
      retry_clr = 1'b1;
    end else begin
      case (state)
        ST_PRST: begin
          if (tmr == PRST_LAST) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_nxt = ST_STAB;
          end else if (tmr == WAIT_LAST) begin
            retry_inc = 1'b1;
            state_nxt = (4'(retry_cnt + 4'd1) == RETRY_MAX) ? ST_FAIL : ST_PRST;
          end
        end
        ST_STAB: begin
          if (!lock_s) state_nxt = ST_WAIT;
          else if (tmr == STAB_LAST) state_nxt = ST_REL;
        end
        ST_REL: begin
          if (!lock_s) begin
            state_nxt = ST_PRST;
          end else if (tmr == REL_LAST) begin
            state_nxt = ST_RUN;
            retry_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_PRST;
            loss_inc  = 1'b1;
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_PRST;
        end
      endcase
    end
  end

  // The shared timer restarts on every state entry (and on a software request
  // even when already in PRST).
  assign tmr_clr = sw_rst_req_i || (state_nxt != state);

  // Shared timer, retry counter and saturating lock-loss counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmr       <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
    end else begin
      if (tmr_clr) tmr <= '0;
      else if (tmr != '1) tmr <= tmr + 1'b1;
      if (retry_clr) retry_cnt <= 4'd0;
      else if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
      if (loss_inc && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign pll_rst_o   = (state == ST_PRST) || (state == ST_FAIL);
  assign sys_rst_n_o = (state == ST_RUN);
  assign lock_ok_o   = (state == ST_RUN);
  assign fail_o      = (state == ST_FAIL);
  assign retry_cnt_o = retry_cnt;
  assign loss_cnt_o  = loss_cnt;

endmodule
